fcvt_port_sched: RTL and testbench

Round-robin scheduler that shares one float-to-integer conversion unit among `N_REQ` requesters, such as the integer pipe and vector/LSU sidecars. It arbitrates valid/ready requests and resolves the dynamic rounding mode against the `frm` CSR. It pipelines each request through one issue register, the combinational converter and one result register. It returns tagged responses in grant order and maintains the sticky NV exception flag.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/float_to_fixed.sv | 88 ++++++++
 rtl/fcvt_port_sched.sv | 142 ++++++++++++++
 tb/tb_fcvt_port_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding-mode encoding, legality check and the
// per-request payload carried through the fcvt scheduler.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    // Widest tag any instance may use; the scheduler keeps TAG_W bits of it.
    localparam int MAX_TAG_W = 8;

    typedef struct packed {
        logic [31:0]          data;
        logic [2:0]           rm;
        logic                 unsigned_op;
        logic [MAX_TAG_W-1:0] tag;
    } fcvt_req_t;

    // Only static modes are legal once DYN has been resolved.
    function automatic logic rm_legal(input logic [2:0] rm);
        return rm inside {RNE, RTZ, RDN, RUP, RMM};
    endfunction

endpackage

// File: rtl/float_to_fixed.sv
// Combinational IEEE-754 single to 32-bit integer converter. Out-of-range,
// NaN and Inf inputs saturate and raise invalid.
module float_to_fixed
    import fpu_pkg::*;
(
    input  logic [31:0] op,
    input  logic [2:0]  rm,
    input  logic        is_unsigned,
    output logic [31:0] int_out,
    output logic        invalid
);

    logic        sign;
    logic [7:0]  expo;
    logic [23:0] mant;
    logic        huge;
    logic        nan;
    logic [54:0] wide;
    logic [31:0] int_mag;
    logic        round_bit;
    logic        sticky;
    logic        inc;
    logic [32:0] mag;

    assign sign = op[31];
    assign expo = op[30:23];
    assign mant = {expo != 8'd0, op[22:0]};
    // Exponent >= 159 means |x| >= 2^32, out of range for every mode.
    assign huge = expo >= 8'd159;
    assign nan  = (expo == 8'hFF) && (op[22:0] != 23'd0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wide      = '0;
        int_mag   = '0;
        round_bit = 1'b0;
        sticky    = 1'b0;
        inc       = 1'b0;
        invalid   = 1'b0;
        int_out   = '0;

        if (expo >= 8'd127 && !huge) begin
            wide      = {31'd0, mant} << (expo - 8'd127);
            int_mag   = wide[54:23];
            round_bit = wide[22];
            sticky    = |wide[21:0];
        end else if (expo == 8'd126) begin
            round_bit = 1'b1;
            sticky    = |mant[22:0];
        end else begin
            sticky    = |mant;
        end

        case (rm)
            RNE:     inc = round_bit & (sticky | int_mag[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (round_bit | sticky);
            RUP:     inc = ~sign & (round_bit | sticky);
            RMM:     inc = round_bit;
            default: inc = 1'b0;
        endcase

        mag = {1'b0, int_mag} + {32'd0, inc};

        if (is_unsigned) begin
            if (nan || (!sign && (huge || mag[32]))) begin
                invalid = 1'b1;
                int_out = 32'hFFFF_FFFF;
            end else if (sign && (huge || mag != 33'd0)) begin
                invalid = 1'b1;
                int_out = 32'd0;
            end else begin
                int_out = mag[31:0];
            end
        end else begin
            if (nan || (!sign && (huge || mag > 33'h0_7FFF_FFFF))) begin
                invalid = 1'b1;
                int_out = 32'h7FFF_FFFF;
            end else if (sign && (huge || mag > 33'h0_8000_0000)) begin
                invalid = 1'b1;
                int_out = 32'h8000_0000;
            end else begin
                int_out = sign ? (~mag[31:0] + 32'd1) : mag[31:0];
            end
        end
    end

endmodule

// File: rtl/fcvt_port_sched.sv
// Round-robin scheduler sharing one float_to_fixed unit among N_REQ ports,
// with an issue register (S1), a result register (S2) and a sticky NV flag.
module fcvt_port_sched
    import fpu_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int TAG_W = 4,
    localparam int PID_W = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][31:0]      req_data,
    input  logic [N_REQ-1:0][2:0]       req_rm,
    input  logic [N_REQ-1:0]            req_unsigned,
    input  logic [N_REQ-1:0][TAG_W-1:0] req_tag,
    input  logic [2:0]                  csr_frm,
    input  logic                        fflags_clr,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [31:0]                 resp_data,
    output logic                        resp_invalid,
    output logic                        resp_illegal_rm,
    output logic [PID_W-1:0]            resp_port,
    output logic [TAG_W-1:0]            resp_tag,
    output logic                        fflags_nv
);

    localparam logic [PID_W:0] N_EXT = (PID_W + 1)'(N_REQ);

    logic             valid1;
    fcvt_req_t        s1;
    logic [PID_W-1:0] port1;
    logic [PID_W-1:0] ptr;
    logic [PID_W-1:0] ptr_next;
    logic [PID_W:0]   cand;
    logic [PID_W:0]   nxt;
    logic             adv2;
    logic             load1;
    logic             grant_valid;
    logic [PID_W-1:0] grant_idx;
    logic             take;
    fcvt_req_t        pick;
    logic [31:0]      cvt_out;
    logic             cvt_invalid;
    logic             s1_legal;
    logic             unused_tag_bits;

    assign adv2  = valid1 & (~resp_valid | resp_ready);
    assign load1 = ~valid1 | adv2;
    assign take  = load1 & grant_valid;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (PID_W + 1)'(i);
            if (cand >= N_EXT) cand = cand - N_EXT;
            if (!grant_valid && req_valid[cand[PID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PID_W-1:0];
            end
        end
    end

    assign nxt      = {1'b0, grant_idx} + (PID_W + 1)'(1);
    assign ptr_next = (nxt == N_EXT) ? '0 : nxt[PID_W-1:0];

    always_comb begin
        req_ready = '0;
        if (take) req_ready[grant_idx] = 1'b1;
    end

    // DYN is resolved against csr_frm in the acceptance cycle.
    always_comb begin
        pick.data        = req_data[grant_idx];
        pick.rm          = (req_rm[grant_idx] == DYN) ? csr_frm : req_rm[grant_idx];
        pick.unsigned_op = req_unsigned[grant_idx];
        pick.tag         = MAX_TAG_W'(req_tag[grant_idx]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: payload flops are reset as well, so resp_* come up as defined zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1 <= 1'b0;
            s1     <= '0;
            port1  <= '0;
            ptr    <= '0;
        end else begin
            if (load1) begin
                valid1 <= take;
                if (take) begin
                    s1    <= pick;
                    port1 <= grant_idx;
                end
            end
            if (take) ptr <= ptr_next;
        end
    end

    assign s1_legal = rm_legal(s1.rm);

    float_to_fixed u_cvt (
        .op          (s1.data),
        .rm          (s1.rm),
        .is_unsigned (s1.unsigned_op),
        .int_out     (cvt_out),
        .invalid     (cvt_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_invalid    <= 1'b0;
            resp_illegal_rm <= 1'b0;
            resp_port       <= '0;
            resp_tag        <= '0;
            fflags_nv       <= 1'b0;
        end else begin
            if (adv2) begin
                resp_valid      <= 1'b1;
                resp_data       <= s1_legal ? cvt_out : 32'd0;
                resp_invalid    <= s1_legal & cvt_invalid;
                resp_illegal_rm <= ~s1_legal;
                resp_port       <= port1;
                resp_tag        <= s1.tag[TAG_W-1:0];
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            // A new invalid result wins over a same-cycle clear.
            if (adv2 && s1_legal && cvt_invalid) fflags_nv <= 1'b1;
            else if (fflags_clr)                 fflags_nv <= 1'b0;
        end
    end

    assign unused_tag_bits = ^s1.tag;

endmodule

// File: tb/tb_fcvt_port_sched.sv
// Directed self-checking bench for fcvt_port_sched: reset, latency, fairness,
// backpressure, rounding-mode resolution, NV flag and reset mid-operation.
module tb_fcvt_port_sched;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][31:0] req_data;
    logic [3:0][2:0] req_rm;
    logic [3:0]      req_unsigned;
    logic [3:0][3:0] req_tag;
    logic [2:0]      csr_frm;
    logic            fflags_clr;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic            resp_invalid;
    logic            resp_illegal_rm;
    logic [1:0]      resp_port;
    logic [3:0]      resp_tag;
    logic            fflags_nv;

    int total = 0;
    int bad   = 0;

    fcvt_port_sched #(.N_REQ(4), .TAG_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_rm          (req_rm),
        .req_unsigned    (req_unsigned),
        .req_tag         (req_tag),
        .csr_frm         (csr_frm),
        .fflags_clr      (fflags_clr),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_invalid    (resp_invalid),
        .resp_illegal_rm (resp_illegal_rm),
        .resp_port       (resp_port),
        .resp_tag        (resp_tag),
        .fflags_nv       (fflags_nv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = '0;
        req_data     = '0;
        req_rm       = '0;
        req_unsigned = '0;
        req_tag      = '0;
        fflags_clr   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] d, input logic [2:0] rm,
                           input logic u, input logic [3:0] t);
        req_valid[p]    = 1'b1;
        req_data[p]     = d;
        req_rm[p]       = rm;
        req_unsigned[p] = u;
        req_tag[p]      = t;
    endtask

    // One request through an empty pipe; returns in the cycle its response is visible.
    task automatic send_one(input int p, input logic [31:0] d, input logic [2:0] rm,
                            input logic u, input logic [3:0] t, input logic clr_mid,
                            input logic [2:0] frm_after);
        logic [3:0] exp_rdy;
        idle_inputs();
        set_req(p, d, rm, u, t);
        exp_rdy = 4'(1 << p);
        #1;
        total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL send.ready got=%b exp=%b", req_ready, exp_rdy); end
        tick();
        req_valid  = '0;
        csr_frm    = frm_after;
        fflags_clr = clr_mid;
        tick();
        fflags_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        idle_inputs();
        resp_ready = 1'b1;
        csr_frm    = 3'b000;
        #2;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset.resp_valid got=%b exp=0", resp_valid); end
        total++; if (fflags_nv !== 1'b0) begin bad++; $display("FAIL reset.fflags_nv got=%b exp=0", fflags_nv); end
        total++; if (resp_data !== 32'd0) begin bad++; $display("FAIL reset.resp_data got=%h exp=0", resp_data); end
        total++; if (resp_port !== 2'd0 || resp_tag !== 4'd0) begin bad++; $display("FAIL reset.port_tag got=%0d/%0d exp=0/0", resp_port, resp_tag); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset.ready_idle got=%b exp=0000", req_ready); end
        req_valid = 4'b0110;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL reset.ready_comb got=%b exp=0010", req_ready); end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        resp_ready = 1'b1;
        idle_inputs();
        set_req(0, 32'h40490FDB, 3'b000, 1'b0, 4'd5);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single.ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single.early got=%b exp=0", resp_valid); end
        tick();
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single.valid got=%b exp=1", resp_valid); end
        total++; if (resp_data !== 32'd3) begin bad++; $display("FAIL single.data got=%h exp=3", resp_data); end
        total++; if (resp_invalid !== 1'b0 || resp_illegal_rm !== 1'b0) begin bad++; $display("FAIL single.flags got=%b%b exp=00", resp_invalid, resp_illegal_rm); end
        total++; if (resp_port !== 2'd0 || resp_tag !== 4'd5) begin bad++; $display("FAIL single.port_tag got=%0d/%0d exp=0/5", resp_port, resp_tag); end
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single.drained got=%b exp=0", resp_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_port;
        logic [31:0] exp_data;
        logic [31:0] vals [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        do_reset();
        idle_inputs();
        resp_ready = 1'b1;
        for (int p = 0; p < 4; p++) set_req(p, vals[p], 3'b000, 1'b0, 4'(p + 1));
        #1;
        for (int k = 0; k < 10; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL fair.ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
            if (k >= 2) begin
                exp_port = 2'((k - 2) % 4);
                exp_data = 32'((k - 2) % 4 + 1);
                total++; if (resp_valid !== 1'b1 || resp_port !== exp_port) begin bad++; $display("FAIL fair.resp[%0d] got=%b/%0d exp=1/%0d", k, resp_valid, resp_port, exp_port); end
                total++; if (resp_data !== exp_data) begin bad++; $display("FAIL fair.data[%0d] got=%h exp=%h", k, resp_data, exp_data); end
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        idle_inputs();
        resp_ready = 1'b0;
        set_req(0, 32'h3F800000, 3'b000, 1'b0, 4'd8);
        set_req(1, 32'h40000000, 3'b000, 1'b0, 4'd9);
        set_req(2, 32'h40400000, 3'b000, 1'b0, 4'd10);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp.ready0 got=%b exp=0001", req_ready); end
        tick();
        total++; if (req_ready !== 4'b0010 || resp_valid !== 1'b0) begin bad++; $display("FAIL bp.ready1 got=%b/%b exp=0010/0", req_ready, resp_valid); end
        tick();
        for (int k = 0; k < 5; k++) begin
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp.full_ready[%0d] got=%b exp=0000", k, req_ready); end
            total++; if (resp_valid !== 1'b1 || resp_port !== 2'd0 || resp_tag !== 4'd8 || resp_data !== 32'd1 || resp_invalid !== 1'b0)
                begin bad++; $display("FAIL bp.hold[%0d] got=%b/%0d/%0d/%h exp=1/0/8/1", k, resp_valid, resp_port, resp_tag, resp_data); end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp.refill got=%b exp=0100", req_ready); end
        tick();
        total++; if (resp_port !== 2'd1 || resp_tag !== 4'd9 || resp_data !== 32'd2) begin bad++; $display("FAIL bp.resp1 got=%0d/%0d/%h exp=1/9/2", resp_port, resp_tag, resp_data); end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp.wrap got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        total++; if (resp_port !== 2'd2 || resp_tag !== 4'd10 || resp_data !== 32'd3) begin bad++; $display("FAIL bp.resp2 got=%0d/%0d/%h exp=2/10/3", resp_port, resp_tag, resp_data); end
        tick();
        total++; if (resp_valid !== 1'b1 || resp_port !== 2'd0 || resp_data !== 32'd1) begin bad++; $display("FAIL bp.resp3 got=%b/%0d/%h exp=1/0/1", resp_valid, resp_port, resp_data); end
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp.empty got=%b exp=0", resp_valid); end
    endtask

    task automatic test_rm();
        resp_ready = 1'b1;
        csr_frm = 3'b011;
        send_one(1, 32'h3FC00000, 3'b111, 1'b0, 4'd3, 1'b0, 3'b010);
        total++; if (resp_data !== 32'd2 || resp_illegal_rm !== 1'b0) begin bad++; $display("FAIL rm.dyn_rup got=%h/%b exp=2/0", resp_data, resp_illegal_rm); end
        total++; if (resp_port !== 2'd1 || resp_tag !== 4'd3) begin bad++; $display("FAIL rm.port_tag got=%0d/%0d exp=1/3", resp_port, resp_tag); end
        tick();
        csr_frm = 3'b101;
        send_one(1, 32'h3FC00000, 3'b111, 1'b0, 4'd4, 1'b0, 3'b000);
        total++; if (resp_illegal_rm !== 1'b1 || resp_data !== 32'd0 || resp_invalid !== 1'b0) begin bad++; $display("FAIL rm.dyn_illegal got=%b/%h/%b exp=1/0/0", resp_illegal_rm, resp_data, resp_invalid); end
        total++; if (fflags_nv !== 1'b0) begin bad++; $display("FAIL rm.nv_untouched got=%b exp=0", fflags_nv); end
        tick();
        send_one(0, 32'h7F800000, 3'b110, 1'b0, 4'd6, 1'b0, 3'b000);
        total++; if (resp_illegal_rm !== 1'b1 || resp_invalid !== 1'b0 || fflags_nv !== 1'b0) begin bad++; $display("FAIL rm.illegal_inf got=%b/%b/%b exp=1/0/0", resp_illegal_rm, resp_invalid, fflags_nv); end
        tick();
        send_one(3, 32'hC0200000, 3'b000, 1'b0, 4'd7, 1'b0, 3'b000);
        total++; if (resp_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rm.rne_neg got=%h exp=fffffffe", resp_data); end
        tick();
        send_one(2, 32'h40200000, 3'b100, 1'b0, 4'd1, 1'b0, 3'b000);
        total++; if (resp_data !== 32'd3) begin bad++; $display("FAIL rm.rmm got=%h exp=3", resp_data); end
        tick();
        send_one(2, 32'hBFC00000, 3'b011, 1'b0, 4'd2, 1'b0, 3'b000);
        total++; if (resp_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rm.rup_neg got=%h exp=ffffffff", resp_data); end
        tick();
    endtask

    task automatic test_bounds();
        resp_ready = 1'b1;
        send_one(0, 32'h4F7FFFFF, 3'b001, 1'b1, 4'd0, 1'b0, 3'b000);
        total++; if (resp_data !== 32'hFFFF_FF00 || resp_invalid !== 1'b0) begin bad++; $display("FAIL bound.u_max got=%h/%b exp=ffffff00/0", resp_data, resp_invalid); end
        tick();
        send_one(0, 32'h4F800000, 3'b001, 1'b1, 4'd0, 1'b0, 3'b000);
        total++; if (resp_invalid !== 1'b1) begin bad++; $display("FAIL bound.u_ovf got=%b exp=1", resp_invalid); end
        tick();
        send_one(0, 32'h4F000000, 3'b001, 1'b0, 4'd0, 1'b0, 3'b000);
        total++; if (resp_invalid !== 1'b1) begin bad++; $display("FAIL bound.s_ovf got=%b exp=1", resp_invalid); end
        tick();
        send_one(0, 32'hCF000000, 3'b001, 1'b0, 4'd0, 1'b0, 3'b000);
        total++; if (resp_data !== 32'h8000_0000 || resp_invalid !== 1'b0) begin bad++; $display("FAIL bound.s_min got=%h/%b exp=80000000/0", resp_data, resp_invalid); end
        tick();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
    endtask

    task automatic test_nv();
        resp_ready = 1'b1;
        csr_frm = 3'b000;
        total++; if (fflags_nv !== 1'b0) begin bad++; $display("FAIL nv.start got=%b exp=0", fflags_nv); end
        send_one(0, 32'h7F800000, 3'b000, 1'b0, 4'd1, 1'b0, 3'b000);
        total++; if (resp_invalid !== 1'b1 || fflags_nv !== 1'b1) begin bad++; $display("FAIL nv.inf got=%b/%b exp=1/1", resp_invalid, fflags_nv); end
        tick();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        total++; if (fflags_nv !== 1'b0) begin bad++; $display("FAIL nv.clear got=%b exp=0", fflags_nv); end
        send_one(2, 32'hBF800000, 3'b001, 1'b1, 4'd2, 1'b0, 3'b000);
        total++; if (resp_invalid !== 1'b1 || fflags_nv !== 1'b1) begin bad++; $display("FAIL nv.neg_unsigned got=%b/%b exp=1/1", resp_invalid, fflags_nv); end
        tick();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        total++; if (fflags_nv !== 1'b0) begin bad++; $display("FAIL nv.clear2 got=%b exp=0", fflags_nv); end
        send_one(3, 32'h7FC00000, 3'b000, 1'b0, 4'd4, 1'b1, 3'b000);
        total++; if (resp_invalid !== 1'b1 || fflags_nv !== 1'b1) begin bad++; $display("FAIL nv.set_wins got=%b/%b exp=1/1", resp_invalid, fflags_nv); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        resp_ready = 1'b0;
        for (int p = 0; p < 4; p++) set_req(p, 32'h7F800000, 3'b000, 1'b0, 4'(p));
        tick();
        tick();
        total++; if (resp_valid !== 1'b1 || fflags_nv !== 1'b1 || req_ready !== 4'b0000) begin bad++; $display("FAIL rmid.full got=%b/%b/%b exp=1/1/0000", resp_valid, fflags_nv, req_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0 || fflags_nv !== 1'b0) begin bad++; $display("FAIL rmid.async got=%b/%b exp=0/0", resp_valid, fflags_nv); end
        rst_n = 1'b1;
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid.first_grant got=%b exp=0001", req_ready); end
        tick();
        total++; if (req_ready !== 4'b0010 || resp_valid !== 1'b0) begin bad++; $display("FAIL rmid.second got=%b/%b exp=0010/0", req_ready, resp_valid); end
        tick();
        total++; if (resp_valid !== 1'b1 || resp_port !== 2'd0) begin bad++; $display("FAIL rmid.resp got=%b/%0d exp=1/0", resp_valid, resp_port); end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_rm();
        test_bounds();
        test_nv();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
